// File: rtl/factorial_pkg.sv
// rtl/factorial_pkg.sv - shared constants and FSM encoding for the factorial job path
package factorial_pkg;

  // Default operand/result width shared with factorial_top
  localparam int FACT_SIZE  = 8;
  // Largest n whose factorial fits in FACT_SIZE bits (5! = 120)
  localparam int FACT_MAX_N = 5;
  // Default request FIFO depth
  localparam int FACT_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_OUT     = 2'd3
  } seq_state_t;

endpackage

// File: rtl/factorial_req_fifo.sv
// rtl/factorial_req_fifo.sv - synchronous DEPTH x SIZE request FIFO with occupancy count
module factorial_req_fifo
  import factorial_pkg::*;
#(
  parameter int SIZE  = FACT_SIZE,
  parameter int DEPTH = FACT_DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_push,
  input  logic [SIZE-1:0] i_data,
  input  logic            i_pop,
  output logic [SIZE-1:0] o_data,
  output logic            o_full,
  output logic            o_empty,
  output logic [CW-1:0]   o_count
);

  logic [SIZE-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  // Full/empty come from the registered count, so a same-cycle pop never frees a slot early
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage array; contents need no reset because the count gates every read
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count holds on push+pop
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/factorial_job_sequencer.sv
// rtl/factorial_job_sequencer.sv - queues n operands and drives factorial_top one job at a time
module factorial_job_sequencer
  import factorial_pkg::*;
#(
  parameter int SIZE  = FACT_SIZE,
  parameter int DEPTH = FACT_DEPTH,
  parameter int MAX_N = FACT_MAX_N,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [SIZE-1:0] i_in_n,
  output logic            o_core_go,
  output logic [SIZE-1:0] o_core_n,
  input  logic            i_core_done,
  input  logic [SIZE-1:0] i_core_result,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [SIZE-1:0] o_out_result,
  output logic            o_out_err,
  output logic [CW-1:0]   o_fifo_count
);

  localparam logic [SIZE-1:0] LP_MAX_N = SIZE'(MAX_N);

  seq_state_t      r_state;
  seq_state_t      w_state_nxt;
  logic            r_core_go;
  logic [SIZE-1:0] r_core_n;
  logic [SIZE-1:0] r_out_result;
  logic            r_out_err;
  logic            w_go_nxt;
  logic [SIZE-1:0] w_n_nxt;
  logic [SIZE-1:0] w_result_nxt;
  logic            w_err_nxt;
  logic            w_pop;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic [SIZE-1:0] w_head;

  factorial_req_fifo #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_in_valid),
    .i_data  (i_in_n),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (o_fifo_count)
  );

  assign o_in_ready   = !w_fifo_full;
  assign o_core_go    = r_core_go;
  assign o_core_n     = r_core_n;
  assign o_out_valid  = (r_state == ST_OUT);
  assign o_out_result = r_out_result;
  assign o_out_err    = r_out_err;

  // State and handshake registers; reset abandons any job in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_core_go    <= 1'b0;
      r_core_n     <= '0;
      r_out_result <= '0;
      r_out_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_core_go    <= w_go_nxt;
      r_core_n     <= w_n_nxt;
      r_out_result <= w_result_nxt;
      r_out_err    <= w_err_nxt;
    end
  end

  // Job sequencing: pop only while core_done is low so a stale done from an abandoned job is never taken
  always_comb begin
    w_state_nxt  = r_state;
    w_go_nxt     = r_core_go;
    w_n_nxt      = r_core_n;
    w_result_nxt = r_out_result;
    w_err_nxt    = r_out_err;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty && !i_core_done) begin
          w_pop = 1'b1;
          if (w_head > LP_MAX_N) begin
            w_result_nxt = '0;
            w_err_nxt    = 1'b1;
            w_state_nxt  = ST_OUT;
          end else begin
            w_n_nxt     = w_head;
            w_go_nxt    = 1'b1;
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (i_core_done) begin
          w_result_nxt = i_core_result;
          w_err_nxt    = 1'b0;
          w_go_nxt     = 1'b0;
          w_state_nxt  = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!i_core_done) begin
          w_state_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        if (i_out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: doc/factorial_job_sequencer.md
Name: factorial_job_sequencer

Overview:
Sits directly upstream and downstream of factorial_top and owns its go/n/done/result handshake. Accepts a stream of n operands via valid/ready and buffers them in a small FIFO. Issues them one at a time to the factorial core and returns each result, with a range-error flag, on a valid/ready output. Lets the rest of the design queue factorial jobs without caring about core timing.

Parameters:
SIZE, 8, operand/result width; must match the factorial_top SIZE.
DEPTH, 4, request FIFO entries; power of two, at least 2.
MAX_N, 5, largest n whose factorial fits in SIZE bits (5! = 120 fits in 8 bits, 6! = 720 does not).

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  request operand valid.
in_ready  out  1  FIFO can accept; high when not full.
in_n  in  SIZE  requested operand.
core_go  out  1  drives factorial_top go.
core_n  out  SIZE  drives factorial_top n; stable whenever core_go is high.
core_done  in  1  factorial_top done (level).
core_result  in  SIZE  factorial_top result; sampled only when core_done is high.
out_valid  out  1  result available.
out_ready  in  1  consumer accepts the result.
out_result  out  SIZE  n!, or 0 when out_err is set.
out_err  out  1  operand exceeded MAX_N; the core was not used.
fifo_count  out  clog2(DEPTH)+1  queued requests, for debug.

Behaviour:
- Reset (rst high at a clock edge) sets the following, taking effect the next cycle regardless of state:
  - FIFO empty, fifo_count = 0, in_ready = 1.
  - core_go = 0, core_n = 0.
  - out_valid = 0, out_result = 0, out_err = 0.
  - FSM in IDLE.
- Reset mid-job abandons the job. If core_done is still high afterwards, the block waits in IDLE until core_done is low before issuing again.
- FIFO rules:
  - A push occurs when in_valid and in_ready are both high.
  - A pop occurs on the IDLE->ISSUE or IDLE->OUT transition.
  - A push and pop in the same cycle leaves the count unchanged.
  - A push is legal into a FIFO that is also popping this cycle. in_ready is still derived from the registered count and is low when count == DEPTH.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, RELEASE, OUT.
  - IDLE: if FIFO is non-empty and core_done is low, pop the head.
    - head > MAX_N: load out_result = 0 and out_err = 1, go to OUT; core_go is never raised.
    - otherwise: load core_n = head, raise core_go, go to ISSUE.
  - ISSUE: core_go held high and core_n held stable. On core_done high: capture core_result into out_result, set out_err = 0, drop core_go, go to RELEASE.
  - RELEASE: core_go low; wait for core_done low, then go to OUT. This guarantees at least one go-low cycle between jobs.
  - OUT: out_valid high; out_result and out_err held stable. When out_ready is high, clear out_valid and go to IDLE.
- Minimum latency from pop to out_valid is core latency + 2 cycles. An error job reaches out_valid the cycle after the pop.
- A single outstanding core job at a time; results return strictly in request order.
- Arithmetic: no arithmetic on results; core_result passes through unmodified. The range check is an unsigned compare, head > MAX_N.
- n = 0 and n = 1 are forwarded to the core; the expected result is 1.
- A hung core (done never rises) holds ISSUE indefinitely; no timeout in this block.

Decomposition:
- Shared package factorial_pkg holds:
  - FSM state encoding, 2-bit: IDLE = 0, ISSUE = 1, RELEASE = 2, OUT = 3.
  - Default SIZE/MAX_N constants used by factorial_top and this block.
- One sub-module, factorial_req_fifo: a synchronous DEPTH x SIZE FIFO with push/pop/full/empty/count, same clk/rst. The FSM lives in factorial_job_sequencer.

Test Plan:
- The bench pairs the block with factorial_top, SIZE = 8, and out_ready held high.
  - Push n = 5 -> core_go rises; out_valid pulses with out_result = 120 and out_err = 0.
  - Push 1, 2, 3, 4 back to back -> outputs in order 1, 2, 6, 24; core_go drops for at least one cycle between jobs.
- Push n = 6 -> out_err = 1 and out_result = 0 the cycle after the pop; core_go stays low throughout.
- Hold out_ready = 0 and push 6 operands:
  - in_ready drops once fifo_count = 4 with one job pending in OUT.
  - Releasing out_ready drains all results in order, e.g. 3, 4, 2, 5, 1 -> 6, 24, 2, 120, 1.
- Push n = 0 -> out_result = 1 and out_err = 0.
- Assert rst during ISSUE of n = 5:
  - Next cycle: out_valid = 0, core_go = 0, fifo_count = 0.
  - A subsequent push of n = 3 returns 6.
